// File: rtl/seq_addsub_unit.sv
// Digit-serial adder/subtractor: one DIGIT-wide adder is reused each cycle,
// working LSB digit first, so a WIDTH-bit operation takes WIDTH/DIGIT cycles.
module seq_addsub_unit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t r_state, w_state_nxt;

  logic [WIDTH-1:0] r_a, r_b, r_acc;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_result;
  logic             r_done, r_cout, r_ovf, r_zero, r_neg;

  logic [DIGIT-1:0] w_sum;
  logic             w_cdig;
  logic             w_msb_cin;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_nxt, w_a_shift, w_b_shift;

  // The single shared digit adder; operands always present their low digit.
  assign {w_cdig, w_sum} = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                         + {{DIGIT{1'b0}}, r_carry};

  // Carry into the digit's top bit; only meaningful on the last digit (MSB).
  assign w_msb_cin = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_sum[DIGIT-1];
  assign w_last    = (r_idx == IW'(N - 1));

  // Operands shift right to expose the next digit; sums enter the accumulator from the top.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign w_acc_nxt = w_sum;
      assign w_a_shift = '0;
      assign w_b_shift = '0;
    end else begin : g_multi
      assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:DIGIT]};
      assign w_a_shift = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
      assign w_b_shift = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= mode ? ~b : b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_a     <= w_a_shift;
          r_b     <= w_b_shift;
          r_acc   <= w_acc_nxt;
          r_carry <= w_cdig;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_result <= w_acc_nxt;
            r_cout   <= w_cdig;
            r_ovf    <= w_msb_cin ^ w_cdig;
            r_zero   <= (w_acc_nxt == '0);
            r_neg    <= w_acc_nxt[WIDTH-1];
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == RUN);
  assign done     = r_done;
  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_ovf;
  assign zero     = r_zero;
  assign negative = r_neg;

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Directed bench for seq_addsub_unit: main instance DIGIT=4, plus DIGIT=1 and
// DIGIT=16 instances sharing the same inputs for the latency-scaling check.
module tb_seq_addsub_unit;

  logic        clk, rst, start, mode, cin;
  logic [15:0] a, b;

  logic        busy, done, cout, overflow, zero, negative;
  logic [15:0] result;
  logic        busy_1, done_1, cout_1, overflow_1, zero_1, negative_1;
  logic [15:0] result_1;
  logic        busy_16, done_16, cout_16, overflow_16, zero_16, negative_16;
  logic [15:0] result_16;

  int n_pass  = 0;
  int n_total = 0;

  seq_addsub_unit #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .overflow(overflow), .zero(zero), .negative(negative)
  );

  seq_addsub_unit #(.WIDTH(16), .DIGIT(1)) dut_d1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy_1), .done(done_1), .result(result_1), .cout(cout_1),
    .overflow(overflow_1), .zero(zero_1), .negative(negative_1)
  );

  seq_addsub_unit #(.WIDTH(16), .DIGIT(16)) dut_d16 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b), .cin(cin),
    .busy(busy_16), .done(done_16), .result(result_16), .cout(cout_16),
    .overflow(overflow_16), .zero(zero_16), .negative(negative_16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present an operation in cycle 0; returns positioned in cycle 1.
  task automatic op_start(input logic m, input logic [15:0] x, input logic [15:0] y,
                          input logic c);
    mode = m; a = x; b = y; cin = c; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // From cycle 1, tick until done; cyc is the done cycle index (0 on timeout).
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int c = 2; c <= 40 && cyc == 0; c++) begin
      tick;
      if (done) cyc = c;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick; tick;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
    n_total++; if (result !== 16'h0000) $display("FAIL reset_result: got %h expected 0000", result); else n_pass++;
    n_total++;
    if ({cout, overflow, zero, negative} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {cout, overflow, zero, negative});
    else n_pass++;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_add_overflow;
    int dc = 0;
    int npulse = 0;
    logic [15:0] mid_res = '0;
    logic [15:0] r = '0;
    logic [4:0]  f = '0;
    op_start(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    n_total++; if (busy !== 1'b1) $display("FAIL add_busy_c1: got %b expected 1", busy); else n_pass++;
    for (int c = 2; c <= 12; c++) begin
      tick;
      if (c == 4) mid_res = result;
      if (done) begin
        npulse++;
        if (dc == 0) begin
          dc = c; r = result; f = {busy, cout, overflow, negative, zero};
        end
      end
    end
    n_total++; if (mid_res !== 16'h0000) $display("FAIL add_result_held: got %h expected 0000", mid_res); else n_pass++;
    n_total++; if (dc !== 5) $display("FAIL add_done_cycle: got %0d expected 5", dc); else n_pass++;
    n_total++; if (npulse !== 1) $display("FAIL add_done_pulses: got %0d expected 1", npulse); else n_pass++;
    n_total++; if (r !== 16'h8000) $display("FAIL add_ovf_result: got %h expected 8000", r); else n_pass++;
    n_total++;
    if (f !== 5'b00110) $display("FAIL add_ovf_flags busy/cout/ovf/neg/zero: got %b expected 00110", f);
    else n_pass++;
  endtask

  task automatic test_sub;
    int dc;
    op_start(1'b1, 16'h0005, 16'h0007, 1'b1);
    wait_done(dc);
    n_total++; if (dc !== 5) $display("FAIL sub1_done_cycle: got %0d expected 5", dc); else n_pass++;
    n_total++; if (result !== 16'hFFFE) $display("FAIL sub1_result: got %h expected fffe", result); else n_pass++;
    n_total++;
    if ({cout, overflow, negative, zero} !== 4'b0010)
      $display("FAIL sub1_flags cout/ovf/neg/zero: got %b expected 0010", {cout, overflow, negative, zero});
    else n_pass++;
    op_start(1'b1, 16'h8000, 16'h0001, 1'b1);
    wait_done(dc);
    n_total++; if (result !== 16'h7FFF) $display("FAIL sub2_result: got %h expected 7fff", result); else n_pass++;
    n_total++;
    if ({cout, overflow, negative, zero} !== 4'b1100)
      $display("FAIL sub2_flags cout/ovf/neg/zero: got %b expected 1100", {cout, overflow, negative, zero});
    else n_pass++;
  endtask

  task automatic test_add_carry;
    int dc;
    op_start(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    wait_done(dc);
    n_total++; if (result !== 16'h0000) $display("FAIL carry_result: got %h expected 0000", result); else n_pass++;
    n_total++;
    if ({cout, overflow, negative, zero} !== 4'b1001)
      $display("FAIL carry_flags cout/ovf/neg/zero: got %b expected 1001", {cout, overflow, negative, zero});
    else n_pass++;
    tick;
    n_total++; if (done !== 1'b0) $display("FAIL done_one_cycle: got %b expected 0", done); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int dc;
    int extra = 0;
    op_start(1'b0, 16'h1111, 16'h2222, 1'b1);
    tick;
    if (done) extra++;
    start = 1'b1; mode = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
    tick;
    if (done) extra++;
    tick;
    if (done) extra++;
    start = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL b2b_busy_c4: got %b expected 1", busy); else n_pass++;
    tick;
    n_total++; if (done !== 1'b1 || extra !== 0)
      $display("FAIL b2b_first_done: got done=%b early=%0d expected done=1 early=0", done, extra);
    else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL b2b_busy_in_done: got %b expected 0", busy); else n_pass++;
    n_total++; if (result !== 16'h3334) $display("FAIL b2b_first_result: got %h expected 3334", result); else n_pass++;
    op_start(1'b0, 16'h0102, 16'h0304, 1'b0);
    n_total++; if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy, done);
    else n_pass++;
    wait_done(dc);
    n_total++; if (dc !== 5) $display("FAIL b2b_second_cycle: got %0d expected 5", dc); else n_pass++;
    n_total++; if (result !== 16'h0406) $display("FAIL b2b_second_result: got %h expected 0406", result); else n_pass++;
  endtask

  task automatic test_reset_abort;
    int dc;
    int stray = 0;
    tick;
    op_start(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_total++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_ctrl: got busy=%b done=%b expected 0 0", busy, done);
    else n_pass++;
    n_total++; if (result !== 16'h0000) $display("FAIL abort_result: got %h expected 0000", result); else n_pass++;
    n_total++; if (zero !== 1'b0) $display("FAIL abort_zero_reg: got %b expected 0", zero); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (done) stray++;
    end
    n_total++; if (stray !== 0) $display("FAIL abort_no_done: got %0d pulses expected 0", stray); else n_pass++;
    op_start(1'b0, 16'h1234, 16'h4321, 1'b0);
    wait_done(dc);
    n_total++; if (dc !== 5 || result !== 16'h5555)
      $display("FAIL post_abort_add: got cycle=%0d result=%h expected cycle=5 result=5555", dc, result);
    else n_pass++;
  endtask

  task automatic test_digit_widths;
    int dc4 = 0, dc1 = 0, dc16 = 0;
    logic [16:0] r4 = '0, r1 = '0, r16 = '0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    op_start(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    for (int c = 2; c <= 25; c++) begin
      tick;
      if (done    && dc4  == 0) begin dc4  = c; r4  = {overflow,    result};    end
      if (done_1  && dc1  == 0) begin dc1  = c; r1  = {overflow_1,  result_1};  end
      if (done_16 && dc16 == 0) begin dc16 = c; r16 = {overflow_16, result_16}; end
    end
    n_total++; if (dc4 !== 5 || r4 !== 17'h18000)
      $display("FAIL d4_add: got cycle=%0d ovf/res=%h expected 5 18000", dc4, r4);
    else n_pass++;
    n_total++; if (dc1 !== 17 || r1 !== 17'h18000)
      $display("FAIL d1_add: got cycle=%0d ovf/res=%h expected 17 18000", dc1, r1);
    else n_pass++;
    n_total++; if (dc16 !== 2 || r16 !== 17'h18000)
      $display("FAIL d16_add: got cycle=%0d ovf/res=%h expected 2 18000", dc16, r16);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_sub;
    test_add_carry;
    test_back_to_back;
    test_reset_abort;
    test_digit_widths;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
